piho_sampler: RTL and testbench

- Downstream measurement stage of the path-integral harmonic oscillator sweep engine.
- Counts completed Monte Carlo sweeps and discards the equilibration sweeps.
- After equilibration, takes one decorrelated sample every N_SKIP sweeps by reading the full path configuration from the shared BRAM.
- Accumulates Σx and Σx² in fixed point for the host-side ⟨x⟩ and ⟨x²⟩ estimates, then raises done.

---
 rtl/piho_sampler.sv | 203 ++++++++++++++++++++
 tb/tb_piho_sampler.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/piho_sampler.sv
// piho_sampler: measurement stage behind the path-integral harmonic oscillator
// sweep engine. It counts sweeps and skips the equilibration sweeps. On every
// N_SKIP-th sweep after that, it reads the path configuration from BRAM and
// accumulates sum(x) and sum((x*x)>>>16) in Q48.16. It raises done after
// N_CONF sweeps.
module piho_sampler #(
  parameter int PATH_N = 5,
  parameter int N_DUMP = 10000,
  parameter int N_SKIP = 600,
  parameter int N_CONF = 130000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sweep_done,
  output logic        busy,
  output logic        rd_en,
  output logic [31:0] rd_addr,
  input  logic [63:0] rd_dout,
  output logic [63:0] sum_x,
  output logic [63:0] sum_x2,
  output logic [31:0] sample_cnt,
  output logic [31:0] sweep_cnt,
  output logic        sample_pulse,
  output logic        done,
  output logic        err
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_READ   = 3'd1;
  localparam logic [2:0] ST_DRAIN  = 3'd2;
  localparam logic [2:0] ST_COMMIT = 3'd3;
  localparam logic [2:0] ST_CHECK  = 3'd4;

  localparam logic [31:0] N_DUMP_L    = 32'(N_DUMP);
  localparam logic [31:0] N_SKIP_L    = 32'(N_SKIP);
  localparam logic [31:0] N_CONF_L    = 32'(N_CONF);
  localparam logic [31:0] LAST_ADDR_L = 32'(8 * PATH_N);

  logic [2:0]  state_q, state_d;
  logic [31:0] skip_q, skip_d;
  logic [31:0] sweep_cnt_q, sweep_cnt_d;
  logic [31:0] sample_cnt_q, sample_cnt_d;
  logic [63:0] sum_x_q, sum_x_d;
  logic [63:0] sum_x2_q, sum_x2_d;
  logic [31:0] rd_addr_q, rd_addr_d;
  logic        rd_en_q, rd_en_d;
  logic        busy_q, busy_d;
  logic        vld_q, vld_d;
  logic        sample_pulse_q, sample_pulse_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic               accept_s;
  logic               take_s;
  logic [31:0]        n_s;
  logic [31:0]        skip_eff_s;
  logic [31:0]        x_s;
  logic signed [63:0] x64_s;
  logic signed [63:0] sq_s;
  logic signed [63:0] sq_sh_s;
  logic               unused_hi_s;

  // The upper half of the BRAM word carries nothing this stage needs.
  assign unused_hi_s = ^rd_dout[63:32];

  // Sign-extend the returned point and form its Q32.32 square, rescaled to Q.16.
  always_comb begin
    x_s     = rd_dout[31:0];
    x64_s   = {{32{x_s[31]}}, x_s};
    sq_s    = x64_s * x64_s;
    sq_sh_s = sq_s >>> 16;
  end

  // Sweep accounting, read sequencing and accumulation.
  always_comb begin
    state_d        = state_q;
    skip_d         = skip_q;
    sweep_cnt_d    = sweep_cnt_q;
    sample_cnt_d   = sample_cnt_q;
    sum_x_d        = sum_x_q;
    sum_x2_d       = sum_x2_q;
    rd_addr_d      = rd_addr_q;
    err_d          = err_q;
    take_s         = 1'b0;
    accept_s       = sweep_done && (state_q == ST_IDLE) && !done_q;
    n_s            = sweep_cnt_q + 32'd1;
    // A zero skip counter means "not yet armed". It behaves as a fresh reload.
    skip_eff_s     = (skip_q == 32'd0) ? N_SKIP_L : skip_q;

    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          sweep_cnt_d = n_s;
          if (n_s > N_DUMP_L) begin
            if (skip_eff_s == 32'd1) begin
              take_s = 1'b1;
              skip_d = N_SKIP_L;
            end else begin
              skip_d = skip_eff_s - 32'd1;
            end
          end else begin
            skip_d = skip_q;
          end
          if (take_s) begin
            state_d   = ST_READ;
            rd_addr_d = 32'd8;
          end else begin
            state_d = ST_CHECK;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        if (rd_addr_q == LAST_ADDR_L) begin
          state_d = ST_DRAIN;
        end else begin
          rd_addr_d = rd_addr_q + 32'd8;
        end
      end
      ST_DRAIN:  state_d = ST_COMMIT;
      ST_COMMIT: state_d = ST_IDLE;
      ST_CHECK:  state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    // Data returned one cycle after each read is folded in at the end of that cycle.
    if (vld_q) begin
      sum_x_d  = sum_x_q + 64'(x64_s);
      sum_x2_d = sum_x2_q + 64'(sq_sh_s);
    end else begin
      sum_x_d  = sum_x_q;
      sum_x2_d = sum_x2_q;
    end

    // Sample count and pulse line up with the COMMIT cycle itself.
    if ((state_d == ST_COMMIT) && (state_q != ST_COMMIT)) begin
      sample_cnt_d = sample_cnt_q + 32'd1;
    end else begin
      sample_cnt_d = sample_cnt_q;
    end

    if (sweep_done && ((state_q != ST_IDLE) || done_q)) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  // Registered status outputs are derived from the next state.
  always_comb begin
    rd_en_d        = (state_d == ST_READ);
    busy_d         = (state_d == ST_READ) || (state_d == ST_DRAIN) || (state_d == ST_COMMIT);
    vld_d          = rd_en_q;
    sample_pulse_d = (state_d == ST_COMMIT) && (state_q != ST_COMMIT);
    done_d         = done_q || ((state_d == ST_IDLE) && (sweep_cnt_d == N_CONF_L));
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      skip_q         <= 32'd0;
      sweep_cnt_q    <= 32'd0;
      sample_cnt_q   <= 32'd0;
      sum_x_q        <= 64'd0;
      sum_x2_q       <= 64'd0;
      rd_addr_q      <= 32'd0;
      rd_en_q        <= 1'b0;
      busy_q         <= 1'b0;
      vld_q          <= 1'b0;
      sample_pulse_q <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      skip_q         <= skip_d;
      sweep_cnt_q    <= sweep_cnt_d;
      sample_cnt_q   <= sample_cnt_d;
      sum_x_q        <= sum_x_d;
      sum_x2_q       <= sum_x2_d;
      rd_addr_q      <= rd_addr_d;
      rd_en_q        <= rd_en_d;
      busy_q         <= busy_d;
      vld_q          <= vld_d;
      sample_pulse_q <= sample_pulse_d;
      done_q         <= done_d;
      err_q          <= err_d;
    end
  end

  assign busy         = busy_q;
  assign rd_en        = rd_en_q;
  assign rd_addr      = rd_addr_q;
  assign sum_x        = sum_x_q;
  assign sum_x2       = sum_x2_q;
  assign sample_cnt   = sample_cnt_q;
  assign sweep_cnt    = sweep_cnt_q;
  assign sample_pulse = sample_pulse_q;
  assign done         = done_q;
  assign err          = err_q;

endmodule

// File: tb/tb_piho_sampler.sv
// Testbench for piho_sampler. A reference model predicts each sample's
// accumulator values and pushes them into a queue. A separate monitor pops one
// entry and compares it whenever sample_pulse is seen.
module tb_piho_sampler;

  localparam int PATH_N  = 5;
  localparam int N_DUMP  = 2;
  localparam int N_SKIP  = 3;
  localparam int N_CONF  = 11;
  localparam int SPACING = 20;

  logic        clk;
  logic        rst;
  logic        sweep_done;
  logic        busy;
  logic        rd_en;
  logic [31:0] rd_addr;
  logic [63:0] rd_dout;
  logic [63:0] sum_x;
  logic [63:0] sum_x2;
  logic [31:0] sample_cnt;
  logic [31:0] sweep_cnt;
  logic        sample_pulse;
  logic        done;
  logic        err;

  piho_sampler #(
    .PATH_N(PATH_N), .N_DUMP(N_DUMP), .N_SKIP(N_SKIP), .N_CONF(N_CONF)
  ) dut (
    .clk(clk), .rst(rst), .sweep_done(sweep_done), .busy(busy), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_dout(rd_dout), .sum_x(sum_x), .sum_x2(sum_x2),
    .sample_cnt(sample_cnt), .sweep_cnt(sweep_cnt), .sample_pulse(sample_pulse),
    .done(done), .err(err)
  );

  typedef struct {
    longint sx;
    longint sx2;
    int     cnt;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] mem [1:PATH_N];

  int     m_n;
  int     m_samples;
  longint m_sx;
  longint m_sx2;
  bit     m_done;
  bit     m_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    int idx;
    idx = int'(a >> 3);
    if (idx >= 1 && idx <= PATH_N) return mem[idx];
    return 32'hDEAD_BEEF;
  endfunction

  // BRAM model with one cycle of read latency. The upper half is random junk.
  always @(posedge clk) begin
    if (rd_en) rd_dout <= {32'($urandom()), mem_rd(rd_addr)};
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (!rst && sample_pulse) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_sample: got pulse expected none (sample_cnt %0d)", sample_cnt);
      end else begin
        mon_e = q.pop_front();
        chk("mon_sum_x", sum_x, mon_e.sx);
        chk("mon_sum_x2", sum_x2, mon_e.sx2);
        chk("mon_sample_cnt", 64'(sample_cnt), 64'(mon_e.cnt));
      end
    end
  end

  task automatic model_clear();
    m_n = 0; m_samples = 0; m_sx = 0; m_sx2 = 0; m_done = 0; m_err = 0;
    q.delete();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_rd_en"}, 64'(rd_en), 64'd0);
    chk({tag, "_rd_addr"}, 64'(rd_addr), 64'd0);
    chk({tag, "_sum_x"}, sum_x, 64'd0);
    chk({tag, "_sum_x2"}, sum_x2, 64'd0);
    chk({tag, "_sample_cnt"}, 64'(sample_cnt), 64'd0);
    chk({tag, "_sweep_cnt"}, 64'(sweep_cnt), 64'd0);
    chk({tag, "_sample_pulse"}, 64'(sample_pulse), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_err"}, 64'(err), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
  endtask

  task automatic fill_const(input logic [31:0] v);
    for (int k = 1; k <= PATH_N; k++) mem[k] = v;
  endtask

  task automatic fill_rand();
    int r;
    for (int k = 1; k <= PATH_N; k++) begin
      r = $urandom_range(0, 7);
      if (r == 0)      mem[k] = 32'h8000_0000;
      else if (r == 1) mem[k] = 32'h7FFF_FFFF;
      else             mem[k] = 32'($urandom());
    end
  endtask

  // Issue one sweep_done, predict the outcome and check cycle-level timing.
  task automatic do_sweep(input bit repulse, input bit rst_mid);
    bit          samp;
    exp_t        e2;
    logic [31:0] x;
    samp = 1'b0;
    if (m_done) begin
      m_err = 1'b1;
    end else begin
      m_n++;
      samp = (m_n > N_DUMP) && (((m_n - N_DUMP) % N_SKIP) == 0);
      if (samp && !rst_mid) begin
        for (int k = 1; k <= PATH_N; k++) begin
          x = mem[k];
          m_sx  += longint'($signed(x));
          m_sx2 += (longint'($signed(x)) * longint'($signed(x))) >>> 16;
        end
        m_samples++;
        e2.sx = m_sx; e2.sx2 = m_sx2; e2.cnt = m_samples;
        q.push_back(e2);
      end
      if (m_n == N_CONF) m_done = 1'b1;
    end
    if (repulse) m_err = 1'b1;
    sweep_done = 1'b1;
    for (int c = 1; c <= PATH_N + 3; c++) begin
      @(posedge clk);
      #1;
      sweep_done = (repulse && c == 3);
      if (samp) begin
        chk("busy_window", 64'(busy), 64'(c <= PATH_N + 2));
        chk("rd_en_window", 64'(rd_en), 64'(c <= PATH_N));
        if (c <= PATH_N) chk("rd_addr_seq", 64'(rd_addr), 64'(8 * c));
        else chk("rd_addr_hold", 64'(rd_addr), 64'(8 * PATH_N));
        chk("sample_pulse_at", 64'(sample_pulse), 64'(c == PATH_N + 2));
        if (c == PATH_N + 2) chk("done_in_commit", 64'(done), 64'd0);
        if (c == PATH_N + 3) chk("done_after_commit", 64'(done), 64'(m_done));
      end else begin
        if (c <= 2) begin
          chk("unsampled_busy", 64'(busy), 64'd0);
          chk("unsampled_rd_en", 64'(rd_en), 64'd0);
          chk("unsampled_pulse", 64'(sample_pulse), 64'd0);
        end
        if (c == 2) chk("unsampled_done", 64'(done), 64'(m_done));
      end
      if (rst_mid && c == 3) begin
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_zero("rst_mid");
        rst = 1'b0;
        model_clear();
        repeat (SPACING) @(posedge clk);
        #1;
        return;
      end
    end
    repeat (SPACING - (PATH_N + 3)) @(posedge clk);
    #1;
    chk("sweep_cnt", 64'(sweep_cnt), 64'(m_n));
    chk("sample_cnt", 64'(sample_cnt), 64'(m_samples));
    chk("done", 64'(done), 64'(m_done));
    chk("err", 64'(err), 64'(m_err));
  endtask

  initial begin
    rst = 1'b1;
    sweep_done = 1'b0;
    rd_dout = 64'd0;
    fill_const(32'd0);
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;

    // Constant x = 1.0. The final sweep is also a sampled sweep.
    fill_const(32'h0001_0000);
    for (int i = 0; i < N_CONF; i++) do_sweep(1'b0, 1'b0);
    chk("p1_sum_x", sum_x, 64'h0000_0000_000F_0000);
    chk("p1_sum_x2", sum_x2, 64'h0000_0000_000F_0000);
    do_sweep(1'b0, 1'b0);
    chk("p1_frozen_sweep_cnt", 64'(sweep_cnt), 64'(N_CONF));

    // Constant x = -2.0.
    do_reset();
    fill_const(32'hFFFE_0000);
    for (int i = 0; i < N_CONF; i++) do_sweep(1'b0, 1'b0);
    chk("p2_sum_x", sum_x, 64'hFFFF_FFFF_FFE2_0000);
    chk("p2_sum_x2", sum_x2, 64'h0000_0000_003C_0000);

    // Reset in the middle of a sample read, then a fresh run with x = 1.0.
    do_reset();
    fill_const(32'h0001_0000);
    for (int i = 0; i < 4; i++) do_sweep(1'b0, 1'b0);
    do_sweep(1'b0, 1'b1);
    for (int i = 0; i < N_CONF; i++) do_sweep(1'b0, 1'b0);
    chk("p3_sum_x", sum_x, 64'h0000_0000_000F_0000);
    chk("p3_sum_x2", sum_x2, 64'h0000_0000_000F_0000);

    // Random configurations, with a protocol violation during sweep 8.
    do_reset();
    for (int i = 1; i <= N_CONF; i++) begin
      fill_rand();
      do_sweep(i == 8, 1'b0);
    end
    chk("p4_sum_x", sum_x, m_sx);
    chk("p4_sum_x2", sum_x2, m_sx2);
    do_sweep(1'b0, 1'b0);

    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
